load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU.
- Takes the ALU result as the effective address, plus rs2 data and funct3, and runs one byte/half/word load or store against a ready-handshaked data memory port.
- Stalls the core via Busy_o until the access completes.
- Returns sign- or zero-extended load data for writeback; flags misaligned/illegal accesses and memory timeouts.

Parameters:
- DATA_WIDTH, 32, data and address width (only 32 supported).
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles to wait for Mem_Ready_i before faulting (1..255).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Req_Valid_i  input  1  EX stage presents an access this cycle.
- Mem_Read_i  input  1  access is a load.
- Mem_Write_i  input  1  access is a store.
- Funct3_i  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU legal for loads only).
- Address_i  input  32  effective address (ALU result).
- Write_Data_i  input  32  store data (rs2).
- Busy_o  output  1  unit occupied; upstream must hold/stall.
- Done_o  output  1  one-cycle completion pulse.
- Load_Data_o  output  32  extended load data; valid when Done_o=1.
- Fault_o  output  1  with Done_o: misaligned, illegal, or timeout.
- Mem_Req_o  output  1  memory request.
- Mem_We_o  output  1  1 = write.
- Mem_Addr_o  output  32  word-aligned address {Address_i[31:2],2'b00}.
- Mem_Byte_En_o  output  4  byte-lane enables.
- Mem_Wdata_o  output  32  lane-positioned store data.
- Mem_Ready_i  input  1  memory completes the request this cycle.
- Mem_Rdata_i  input  32  read word, valid with Mem_Ready_i.

Behaviour:
- **Reset** (reset=0, async, any state):
  - State=IDLE; all outputs 0.
  - Mem_Req_o drops immediately, including mid-ACCESS.
  - Timeout counter=0. The aborted access produces no Done_o.
- **FSM states:** IDLE, ACCESS, RESP, ERR. All outputs are registered.
- **IDLE:**
  - Accept when Req_Valid_i=1 and exactly one of Mem_Read_i/Mem_Write_i is 1.
  - Neither set → ignored.
  - Both set → ERR.
- **Legality check at accept:**
  - H/HU need Address_i[0]=0; W needs Address_i[1:0]=00.
  - Funct3 outside the listed codes, or BU/HU on a store → ERR.
  - Otherwise latch the request and go to ACCESS.
- **ACCESS:**
  - Mem_Req_o=1, Busy_o=1.
  - Mem_We_o, Mem_Addr_o, Mem_Byte_En_o and Mem_Wdata_o stay stable until Mem_Ready_i is sampled 1.
  - On ready: capture the extended load data (stores: Load_Data_o=0), go to RESP.
  - Counter increments each ACCESS cycle without ready. Reaching TIMEOUT_CYCLES → RESP with Fault_o=1 and Load_Data_o=0.
  - Ready arriving in the same cycle the counter would hit the limit counts as success.
- **RESP:** Done_o=1 and Busy_o=0 for one cycle, Mem_Req_o=0, then IDLE. Req_Valid_i during RESP is ignored.
- **ERR:** Done_o=1, Fault_o=1, Busy_o=0 for one cycle. No memory request is issued. Then IDLE.
- **Busy_o:** 1 only in ACCESS. Req_Valid_i outside IDLE is ignored; upstream must stall on Busy_o and Done_o.
- **Latency:** accept at edge N → Mem_Req_o high from cycle N+1 → ready in cycle N+1 gives Done_o in N+2. Minimum is 2 cycles; error path is 1 cycle.
- **Byte enables:**
  - B: 4'b0001 << addr[1:0].
  - H: 0011 (addr[1]=0) or 1100.
  - W: 1111.
- **Store data:**
  - B: rs2[7:0] replicated to all 4 lanes.
  - H: rs2[15:0] replicated to both halves.
  - W: rs2 unchanged.
- **Load extract:** select the lane by addr[1:0] (H by addr[1]). B/H are sign-extended from bit 7/15; BU/HU are zero-extended.
- Load_Data_o holds its value until the next completion.

Test Plan:
- LW at 0x00000104, memory returns 0xDEADBEEF with Mem_Ready_i in the first ACCESS cycle:
  - Mem_Addr_o=0x104, Byte_En=1111.
  - Done_o exactly 2 cycles after accept, Load_Data_o=0xDEADBEEF, Fault_o=0.
- LB at 0x103 and LBU at 0x103, Rdata=0x80AA5511:
  - Load_Data_o=0xFFFFFF80, then 0x00000080.
- SH at 0x206, rs2=0x1234ABCD, Mem_Ready_i delayed 3 cycles:
  - Mem_Addr_o=0x204, Byte_En=1100, Wdata=0xABCDABCD, all stable over the wait.
  - Busy_o high for 4 cycles, then Done_o.
- LW at 0x102 → ERR:
  - Done_o=1, Fault_o=1 one cycle after accept; Mem_Req_o never asserts.
  - Repeat with Read=Write=1 → same response.
- Mem_Ready_i held 0 with TIMEOUT_CYCLES=16:
  - Done_o and Fault_o after 16 ACCESS cycles, Load_Data_o=0.
- reset pulsed low during ACCESS:
  - Mem_Req_o and Busy_o go 0 immediately, no Done_o.
  - A new LW after release completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Data-memory port between the load/store unit (master) and the memory (slave).
//
// Handshake: while Mem_Req_o is 1 the master holds Mem_We_o, Mem_Addr_o,
// Mem_Byte_En_o and Mem_Wdata_o stable. The request completes on the first
// rising edge at which Mem_Ready_i is 1. Mem_Rdata_i is only meaningful in
// that same cycle. Mem_Ready_i while Mem_Req_o is 0 has no effect.
interface load_store_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    Mem_Req_o;
  logic                    Mem_We_o;
  logic [DATA_WIDTH-1:0]   Mem_Addr_o;
  logic [DATA_WIDTH/8-1:0] Mem_Byte_En_o;
  logic [DATA_WIDTH-1:0]   Mem_Wdata_o;
  logic                    Mem_Ready_i;
  logic [DATA_WIDTH-1:0]   Mem_Rdata_i;

  modport master (
    output Mem_Req_o, Mem_We_o, Mem_Addr_o, Mem_Byte_En_o, Mem_Wdata_o,
    input  Mem_Ready_i, Mem_Rdata_i
  );

  modport slave (
    input  Mem_Req_o, Mem_We_o, Mem_Addr_o, Mem_Byte_En_o, Mem_Wdata_o,
    output Mem_Ready_i, Mem_Rdata_i
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: takes the ALU result as effective address, runs one
// byte/half/word access over the data-memory port, stalls the core while the
// access is outstanding and returns extended load data plus a fault flag.
// State_o exposes the FSM state (0 IDLE, 1 ACCESS, 2 RESP, 3 ERR).
module load_store_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Req_Valid_i,
  input  logic                  Mem_Read_i,
  input  logic                  Mem_Write_i,
  input  logic [2:0]            Funct3_i,
  input  logic [DATA_WIDTH-1:0] Address_i,
  input  logic [DATA_WIDTH-1:0] Write_Data_i,
  output logic                  Busy_o,
  output logic                  Done_o,
  output logic [DATA_WIDTH-1:0] Load_Data_o,
  output logic                  Fault_o,
  output logic [1:0]            State_o,
  load_store_unit_if.master     mem
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ERR    = 2'd3
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                  state, state_next;
  logic [7:0]              cnt;
  logic                    we_q;
  logic [2:0]              f3_q;
  logic [1:0]              off_q;
  logic [DATA_WIDTH-1:0]   addr_q;
  logic [3:0]              be_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   load_data_q;
  logic                    fault_q;

  logic                    one_op;
  logic                    both_op;
  logic                    legal;
  logic [3:0]              be_new;
  logic [DATA_WIDTH-1:0]   wdata_new;
  logic                    go_access;
  logic                    go_err;
  logic                    timeout_hit;
  logic [7:0]              lane_byte;
  logic [15:0]             lane_half;
  logic [DATA_WIDTH-1:0]   load_ext;

  assign one_op      = Mem_Read_i ^ Mem_Write_i;
  assign both_op     = Mem_Read_i & Mem_Write_i;
  assign go_access   = (state == IDLE) && Req_Valid_i && one_op && legal;
  assign go_err      = (state == IDLE) && Req_Valid_i && (both_op || (one_op && !legal));
  assign timeout_hit = (state == ACCESS) && !mem.Mem_Ready_i && (cnt == TO_LAST);

  // Decode size/alignment legality, lane enables and lane-positioned store data
  always_comb begin
    legal     = 1'b0;
    be_new    = 4'b0000;
    wdata_new = Write_Data_i;
    case (Funct3_i)
      3'b000: begin
        legal     = 1'b1;
        be_new    = 4'b0001 << Address_i[1:0];
        wdata_new = {4{Write_Data_i[7:0]}};
      end
      3'b001: begin
        legal     = !Address_i[0];
        be_new    = Address_i[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{Write_Data_i[15:0]}};
      end
      3'b010: begin
        legal     = (Address_i[1:0] == 2'b00);
        be_new    = 4'b1111;
      end
      3'b100: begin
        legal     = Mem_Read_i;
        be_new    = 4'b0001 << Address_i[1:0];
        wdata_new = {4{Write_Data_i[7:0]}};
      end
      3'b101: begin
        legal     = Mem_Read_i && !Address_i[0];
        be_new    = Address_i[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{Write_Data_i[15:0]}};
      end
      default: legal = 1'b0;
    endcase
  end

  // Pick the addressed lane of the read word and sign/zero-extend it
  always_comb begin
    case (off_q)
      2'd0:    lane_byte = mem.Mem_Rdata_i[7:0];
      2'd1:    lane_byte = mem.Mem_Rdata_i[15:8];
      2'd2:    lane_byte = mem.Mem_Rdata_i[23:16];
      default: lane_byte = mem.Mem_Rdata_i[31:24];
    endcase
    lane_half = off_q[1] ? mem.Mem_Rdata_i[31:16] : mem.Mem_Rdata_i[15:0];
    case (f3_q)
      3'b000:  load_ext = {{(DATA_WIDTH-8){lane_byte[7]}}, lane_byte};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, lane_byte};
      3'b001:  load_ext = {{(DATA_WIDTH-16){lane_half[15]}}, lane_half};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, lane_half};
      default: load_ext = mem.Mem_Rdata_i;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (go_err)         state_next = ERR;
        else if (go_access) state_next = ACCESS;
      end
      ACCESS: begin
        if (mem.Mem_Ready_i || timeout_hit) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, timeout counter, load-data and fault capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= 8'd0;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      addr_q      <= '0;
      be_q        <= 4'b0000;
      wdata_q     <= '0;
      load_data_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      if (go_access) begin
        cnt     <= 8'd0;
        we_q    <= Mem_Write_i;
        f3_q    <= Funct3_i;
        off_q   <= Address_i[1:0];
        addr_q  <= {Address_i[DATA_WIDTH-1:2], 2'b00};
        be_q    <= be_new;
        wdata_q <= wdata_new;
      end
      if (go_err) begin
        fault_q     <= 1'b1;
        load_data_q <= '0;
      end
      if (state == ACCESS) begin
        if (mem.Mem_Ready_i) begin
          fault_q     <= 1'b0;
          load_data_q <= we_q ? '0 : load_ext;
        end else begin
          cnt <= cnt + 8'd1;
          if (timeout_hit) begin
            fault_q     <= 1'b1;
            load_data_q <= '0;
          end
        end
      end
    end
  end

  // Outputs decoded from registered state and latched request
  always_comb begin
    Busy_o            = (state == ACCESS);
    Done_o            = (state == RESP) || (state == ERR);
    Fault_o           = Done_o && fault_q;
    Load_Data_o       = load_data_q;
    State_o           = state;
    mem.Mem_Req_o     = (state == ACCESS);
    mem.Mem_We_o      = (state == ACCESS) && we_q;
    mem.Mem_Addr_o    = addr_q;
    mem.Mem_Byte_En_o = be_q;
    mem.Mem_Wdata_o   = wdata_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit: a vector table of accesses with
// hand-computed bus/response values, plus reset, ignored-request and
// mid-access reset sequences.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        Req_Valid_i;
  logic        Mem_Read_i;
  logic        Mem_Write_i;
  logic [2:0]  Funct3_i;
  logic [31:0] Address_i;
  logic [31:0] Write_Data_i;
  logic        Busy_o;
  logic        Done_o;
  logic [31:0] Load_Data_o;
  logic        Fault_o;
  logic [1:0]  State_o;

  load_store_unit_if #(.DATA_WIDTH(32)) mem ();

  load_store_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .Req_Valid_i  (Req_Valid_i),
    .Mem_Read_i   (Mem_Read_i),
    .Mem_Write_i  (Mem_Write_i),
    .Funct3_i     (Funct3_i),
    .Address_i    (Address_i),
    .Write_Data_i (Write_Data_i),
    .Busy_o       (Busy_o),
    .Done_o       (Done_o),
    .Load_Data_o  (Load_Data_o),
    .Fault_o      (Fault_o),
    .State_o      (State_o),
    .mem          (mem.master)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;   // ACCESS cycles before ready; large = never
    logic        err;     // expect the one-cycle error response
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    int          e_busy;
    logic        e_fault;
    logic [31:0] e_load;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    Req_Valid_i  = 1'b0;
    Mem_Read_i   = 1'b0;
    Mem_Write_i  = 1'b0;
    Funct3_i     = 3'b000;
    Address_i    = 32'h0;
    Write_Data_i = 32'h0;
  endtask

  // Drive one access from IDLE and check bus, latency and response
  task automatic run_vec(input vec_t v, input int idx);
    int busy_n;
    int bus_bad;
    int cyc;
    @(negedge clk);
    Req_Valid_i  = 1'b1;
    Mem_Read_i   = v.rd;
    Mem_Write_i  = v.wr;
    Funct3_i     = v.f3;
    Address_i    = v.addr;
    Write_Data_i = v.wdata;
    @(negedge clk);
    idle_inputs();
    if (v.err) begin
      check($sformatf("v%0d_err_done", idx), 32'(Done_o), 32'd1);
      check($sformatf("v%0d_err_fault", idx), 32'(Fault_o), 32'd1);
      check($sformatf("v%0d_err_req", idx), {31'd0, mem.Mem_Req_o} | {31'd0, Busy_o}, 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_err_after", idx), {31'd0, Done_o} | {31'd0, mem.Mem_Req_o}, 32'd0);
      return;
    end
    busy_n  = 0;
    bus_bad = 0;
    cyc     = 0;
    while (Done_o !== 1'b1 && cyc < 40) begin
      if (Busy_o === 1'b1) busy_n++;
      if (mem.Mem_Req_o !== 1'b1 || mem.Mem_Addr_o !== v.e_addr ||
          mem.Mem_Byte_En_o !== v.e_be || mem.Mem_We_o !== v.wr ||
          (v.wr && mem.Mem_Wdata_o !== v.e_wdata))
        bus_bad++;
      mem.Mem_Ready_i = (cyc == v.delay);
      mem.Mem_Rdata_i = (cyc == v.delay) ? v.rdata : 32'h5A5A5A5A;
      @(negedge clk);
      cyc++;
    end
    mem.Mem_Ready_i = 1'b0;
    mem.Mem_Rdata_i = 32'h0;
    check($sformatf("v%0d_done", idx), 32'(Done_o), 32'd1);
    check($sformatf("v%0d_bus_bad_cycles", idx), 32'(bus_bad), 32'd0);
    check($sformatf("v%0d_busy_cycles", idx), 32'(busy_n), 32'(v.e_busy));
    check($sformatf("v%0d_fault", idx), 32'(Fault_o), 32'(v.e_fault));
    check($sformatf("v%0d_load", idx), Load_Data_o, v.e_load);
    check($sformatf("v%0d_resp_req_busy", idx), {31'd0, mem.Mem_Req_o} | {31'd0, Busy_o}, 32'd0);
    @(negedge clk);
    check($sformatf("v%0d_done_pulse", idx), 32'(Done_o), 32'd0);
    check($sformatf("v%0d_load_hold", idx), Load_Data_o, v.e_load);
  endtask

  initial begin
    // field order: rd wr f3 addr wdata rdata delay err e_addr e_be e_wdata e_busy e_fault e_load
    vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'hDEADBEEF, 0, 1'b0, 32'h104, 4'hF, 32'h0, 1, 1'b0, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80AA5511, 0, 1'b0, 32'h100, 4'h8, 32'h0, 1, 1'b0, 32'hFFFFFF80};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80AA5511, 0, 1'b0, 32'h100, 4'h8, 32'h0, 1, 1'b0, 32'h00000080};
    vecs[3]  = '{1'b0, 1'b1, 3'b001, 32'h206, 32'h1234ABCD, 32'h0, 3, 1'b0, 32'h204, 4'hC, 32'hABCDABCD, 4, 1'b0, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80AA5511, 1, 1'b0, 32'h100, 4'hC, 32'h0, 2, 1'b0, 32'hFFFF80AA};
    vecs[5]  = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 32'h80AA9511, 0, 1'b0, 32'h100, 4'h3, 32'h0, 1, 1'b0, 32'h00009511};
    vecs[6]  = '{1'b0, 1'b1, 3'b000, 32'h301, 32'h000000A5, 32'h0, 2, 1'b0, 32'h300, 4'h2, 32'hA5A5A5A5, 3, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0, 0, 1'b0, 32'h400, 4'hF, 32'hCAFEF00D, 1, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 1'b1, 32'h0, 4'h0, 32'h0, 0, 1'b1, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 32'h0, 0, 1'b1, 32'h0, 4'h0, 32'h0, 0, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 1'b1, 32'h0, 4'h0, 32'h0, 0, 1'b1, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 1'b1, 32'h0, 4'h0, 32'h0, 0, 1'b1, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h11111111, 1000, 1'b0, 32'h500, 4'hF, 32'h0, 16, 1'b1, 32'h0};
    vecs[13] = '{1'b1, 1'b0, 3'b010, 32'h504, 32'h0, 32'h13579BDF, 15, 1'b0, 32'h504, 4'hF, 32'h0, 16, 1'b0, 32'h13579BDF};
    vecs[14] = '{1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 32'h12117F00, 0, 1'b0, 32'h100, 4'h4, 32'h0, 1, 1'b0, 32'h00000011};
    vecs[15] = '{1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 1'b1, 32'h0, 4'h0, 32'h0, 0, 1'b1, 32'h0};

    // Reset state
    reset = 1'b0;
    idle_inputs();
    mem.Mem_Ready_i = 1'b0;
    mem.Mem_Rdata_i = 32'h0;
    #1;
    check("reset_state", 32'(State_o), 32'd0);
    check("reset_flags", {28'd0, Busy_o, Done_o, Fault_o, mem.Mem_Req_o}, 32'd0);
    check("reset_load", Load_Data_o, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Valid with neither read nor write is ignored
    @(negedge clk);
    Req_Valid_i = 1'b1;
    Address_i   = 32'h100;
    Funct3_i    = 3'b010;
    @(negedge clk);
    idle_inputs();
    check("ignored_state", 32'(State_o), 32'd0);
    check("ignored_flags", {30'd0, Busy_o, Done_o}, 32'd0);

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Reset asserted mid-ACCESS drops the request at once, no completion
    @(negedge clk);
    Req_Valid_i = 1'b1;
    Mem_Read_i  = 1'b1;
    Funct3_i    = 3'b010;
    Address_i   = 32'h600;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    check("pre_reset_busy", {30'd0, Busy_o, mem.Mem_Req_o}, 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_req_busy", {30'd0, Busy_o, mem.Mem_Req_o}, 32'd0);
    check("async_reset_state", 32'(State_o), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    begin
      int done_seen;
      done_seen = 0;
      repeat (3) begin
        @(negedge clk);
        if (Done_o === 1'b1 || mem.Mem_Req_o === 1'b1) done_seen++;
      end
      check("no_done_after_reset", 32'(done_seen), 32'd0);
    end
    run_vec(vecs[0], 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
